qtu_pkt_sched: RTL and testbench

Front-end scheduler for the Q-table update / find-my-best datapath (QTU_FMB). It queues neighbour-info packets from the RX parser and drops self-echoes. It presents one packet at a time to QTU_FMB as a single-cycle en pulse with stable field registers, then waits for QTUFMB_done. Heartbeat round starts take priority: a HB_Reset pulse is issued, the stale queue is flushed, and the table-clear time is waited out.

---
 rtl/qtu_pkt_sched.sv | 209 ++++++++++++++++++++
 tb/tb_qtu_pkt_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtu_pkt_sched.sv
// Front-end scheduler for QTU_FMB: queues neighbour-info packets, filters self-echoes,
// issues one en pulse per packet and services heartbeat table resets with priority.
module qtu_pkt_sched #(
    parameter int WORD_WIDTH  = 16,
    parameter int DEPTH       = 4,
    parameter int HB_WAIT_CYC = 40,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [WORD_WIDTH-1:0] pkt_srcID,
    input  logic [WORD_WIDTH-1:0] pkt_srcHops,
    input  logic [WORD_WIDTH-1:0] pkt_qValue,
    input  logic [WORD_WIDTH-1:0] pkt_energy,
    input  logic [WORD_WIDTH-1:0] pkt_hopsFromCH,
    input  logic [WORD_WIDTH-1:0] pkt_chosenCH,
    input  logic                  hb_req,
    output logic                  en,
    output logic                  HB_Reset,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    input  logic                  QTUFMB_done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [7:0]            drop_cnt,
    output logic [15:0]           proc_cnt,
    output logic [2:0]            dbgState
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_MAX = (HB_WAIT_CYC > TIMEOUT_CYC) ? HB_WAIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] HB_LOAD   = CNT_W'(HB_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] srcId;
        logic [WORD_WIDTH-1:0] srcHops;
        logic [WORD_WIDTH-1:0] qValue;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] hopsFromCh;
        logic [WORD_WIDTH-1:0] chosenCh;
    } pktT;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HB_PULSE  = 3'd1,
        HB_WAIT   = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4
    } stateT;

    stateT            state;
    stateT            stateNext;
    pktT              mem [DEPTH];
    pktT              fReg;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic [CNT_W-1:0] timer;
    logic             hbPending;

    logic accept;
    logic isEcho;
    logic push;
    logic drop;
    logic pop;
    logic flush;
    logic timerZero;

    // A packet transfers on any rising edge with pkt_valid && pkt_ready; pkt_ready
    // depends only on registered state, never on pkt_valid.
    assign accept    = pkt_valid && pkt_ready;
    assign isEcho    = (pkt_srcID == myNodeID);
    assign push      = accept && !isEcho;
    assign drop      = accept && isEcho;
    assign pop       = (state == IDLE) && !hbPending && (count != '0);
    assign flush     = (state == HB_PULSE);
    assign timerZero = (timer == '0);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; heartbeats win every IDLE decision
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (hbPending) begin
                    stateNext = HB_PULSE;
                end else if (count != '0) begin
                    stateNext = ISSUE;
                end
            end
            HB_PULSE:  stateNext = HB_WAIT;
            HB_WAIT:   if (timerZero) stateNext = IDLE;
            ISSUE:     stateNext = WAIT_DONE;
            WAIT_DONE: if (QTUFMB_done || timerZero) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        en        = (state == ISSUE);
        HB_Reset  = (state == HB_PULSE);
        busy      = (state != IDLE);
        pkt_ready = (count < DEPTH_C) && (state != HB_PULSE) && (state != HB_WAIT);
        dbgState  = state;
    end

    // Queue pointers; a flush discards anything pushed on the edge that entered HB_PULSE
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= '{srcId: pkt_srcID, srcHops: pkt_srcHops, qValue: pkt_qValue,
                            energy: pkt_energy, hopsFromCh: pkt_hopsFromCH,
                            chosenCh: pkt_chosenCH};
        end
    end

    // Shared down-counter for the heartbeat wait and the completion timeout
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            timer <= '0;
        end else begin
            case (state)
                HB_PULSE:  timer <= HB_LOAD;
                ISSUE:     timer <= TO_LOAD;
                HB_WAIT:   if (!timerZero) timer <= timer - 1'b1;
                WAIT_DONE: if (!timerZero) timer <= timer - 1'b1;
                default:   timer <= timer;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hbPending <= 1'b0;
        end else if (state == HB_PULSE) begin
            hbPending <= hb_req;
        end else begin
            hbPending <= hbPending | hb_req;
        end
    end

    // Field registers hold their last value through completion, flush and timeout
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fReg <= '0;
        end else if (pop) begin
            fReg <= mem[rdPtr];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_cnt    <= '0;
            proc_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
            if ((state == WAIT_DONE) && QTUFMB_done) proc_cnt <= proc_cnt + 1'b1;
            if ((state == WAIT_DONE) && !QTUFMB_done && timerZero) timeout_err <= 1'b1;
        end
    end

    assign fSourceID   = fReg.srcId;
    assign fSourceHops = fReg.srcHops;
    assign fQValue     = fReg.qValue;
    assign fEnergyLeft = fReg.energy;
    assign fHopsFromCH = fReg.hopsFromCh;
    assign fChosenCH   = fReg.chosenCh;

endmodule

// File: tb/tb_qtu_pkt_sched.sv
// Bench for qtu_pkt_sched: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model built from packet queues and phase timers.
module tb_qtu_pkt_sched;

    localparam int W           = 16;
    localparam int DEPTH       = 4;
    localparam int HB_WAIT_CYC = 40;
    localparam int TIMEOUT_CYC = 64;

    typedef struct packed {
        logic [W-1:0] src;
        logic [W-1:0] hops;
        logic [W-1:0] q;
        logic [W-1:0] energy;
        logic [W-1:0] hfc;
        logic [W-1:0] ch;
    } pktT;

    logic         clk = 1'b0;
    logic         nrst;
    logic [W-1:0] myNodeID;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [W-1:0] pkt_srcID, pkt_srcHops, pkt_qValue, pkt_energy, pkt_hopsFromCH, pkt_chosenCH;
    logic         hb_req;
    logic         en;
    logic         HB_Reset;
    logic [W-1:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
    logic         QTUFMB_done;
    logic         busy;
    logic         timeout_err;
    logic [7:0]   drop_cnt;
    logic [15:0]  proc_cnt;
    logic [2:0]   dbgState;

    qtu_pkt_sched #(
        .WORD_WIDTH(W), .DEPTH(DEPTH), .HB_WAIT_CYC(HB_WAIT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .nrst(nrst), .myNodeID(myNodeID),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_srcID(pkt_srcID), .pkt_srcHops(pkt_srcHops), .pkt_qValue(pkt_qValue),
        .pkt_energy(pkt_energy), .pkt_hopsFromCH(pkt_hopsFromCH), .pkt_chosenCH(pkt_chosenCH),
        .hb_req(hb_req), .en(en), .HB_Reset(HB_Reset),
        .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue),
        .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
        .QTUFMB_done(QTUFMB_done), .busy(busy), .timeout_err(timeout_err),
        .drop_cnt(drop_cnt), .proc_cnt(proc_cnt), .dbgState(dbgState)
    );

    // Clock
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state
    pktT mq[$];
    bit  mHbPend;
    int  mHbLeft;
    bit  mIssuing;
    bit  mWaiting;
    int  mWaitAge;
    pktT mF;
    int  mDrop;
    int  mProc;
    bit  mTout;
    bit  doneMode;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic pktT mkPkt(input int s, input int h, input int q, input int e,
                                  input int hf, input int c);
        pktT p;
        p.src = W'(s); p.hops = W'(h); p.q = W'(q);
        p.energy = W'(e); p.hfc = W'(hf); p.ch = W'(c);
        return p;
    endfunction

    function automatic void modelReset();
        mq.delete();
        exp_q.delete();
        mHbPend  = 1'b0;
        mHbLeft  = 0;
        mIssuing = 1'b0;
        mWaiting = 1'b0;
        mWaitAge = 0;
        mF       = '0;
        mDrop    = 0;
        mProc    = 0;
        mTout    = 1'b0;
    endfunction

    function automatic bit modelReady();
        return (mq.size() < DEPTH) && (mHbLeft == 0);
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelStep();
        bit  idle    = (mHbLeft == 0) && !mIssuing && !mWaiting;
        bit  acc     = pkt_valid && modelReady();
        bit  pulse   = (mHbLeft == HB_WAIT_CYC + 1);
        bit  doIssue = idle && !mHbPend && (mq.size() > 0);
        bit  goHb    = idle && mHbPend;
        pktT inPkt   = {pkt_srcID, pkt_srcHops, pkt_qValue, pkt_energy, pkt_hopsFromCH, pkt_chosenCH};
        if (!nrst) begin
            modelReset();
            return;
        end
        if (mWaiting) begin
            if (QTUFMB_done) begin
                mProc    = (mProc + 1) % 65536;
                mWaiting = 1'b0;
            end else if (mWaitAge == TIMEOUT_CYC - 1) begin
                mTout    = 1'b1;
                mWaiting = 1'b0;
            end else begin
                mWaitAge++;
            end
        end
        if (mIssuing) begin
            mWaiting = 1'b1;
            mWaitAge = 0;
        end
        mIssuing = doIssue;
        if (doIssue) begin
            mF = mq.pop_front();
            exp_q.push_back(mF.src);
        end
        if (acc) begin
            if (pkt_srcID == myNodeID) begin
                if (mDrop < 255) mDrop++;
            end else begin
                mq.push_back(inPkt);
            end
        end
        if (pulse) mq.delete();
        mHbPend = pulse ? hb_req : (mHbPend | hb_req);
        if (goHb) mHbLeft = HB_WAIT_CYC + 1;
        else if (mHbLeft > 0) mHbLeft--;
    endtask

    task automatic checkOutputs();
        bit expBusy = (mHbLeft > 0) || mIssuing || mWaiting;
        check("en", en, mIssuing);
        check("hb_reset", HB_Reset, (mHbLeft == HB_WAIT_CYC + 1));
        check("busy", busy, expBusy);
        check("dbg_idle", (dbgState == 3'd0), !expBusy);
        check("pkt_ready", pkt_ready, modelReady());
        check("fields", {fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH}, mF);
        check("timeout_err", timeout_err, mTout);
        check("drop_cnt", drop_cnt, 128'(mDrop));
        check("proc_cnt", proc_cnt, 128'(mProc));
        if (en === 1'b1) begin
            check("sb_pending", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check("sb_order", fSourceID, exp_q.pop_front());
        end
    endtask

    // Driver tasks: inputs are set on the falling edge, outputs compared on the next one.
    task automatic step();
        modelStep();
        @(negedge clk);
        checkOutputs();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) step();
    endtask

    task automatic sendPkt(input pktT p);
        pkt_valid = 1'b1;
        {pkt_srcID, pkt_srcHops, pkt_qValue, pkt_energy, pkt_hopsFromCH, pkt_chosenCH} = p;
        step();
        pkt_valid = 1'b0;
    endtask

    task automatic pulseDone();
        QTUFMB_done = 1'b1;
        step();
        QTUFMB_done = 1'b0;
    endtask

    task automatic pulseHb();
        hb_req = 1'b1;
        step();
        hb_req = 1'b0;
    endtask

    task automatic assertReset();
        nrst = 1'b0;
        #1;
        modelReset();
        checkOutputs();
        step();
        step();
        nrst = 1'b1;
    endtask

    initial begin
        nrst        = 1'b0;
        myNodeID    = 16'd25;
        pkt_valid   = 1'b0;
        hb_req      = 1'b0;
        QTUFMB_done = 1'b0;
        {pkt_srcID, pkt_srcHops, pkt_qValue, pkt_energy, pkt_hopsFromCH, pkt_chosenCH} = '0;
        doneMode    = 1'b1;
        modelReset();
        idleCycles(3);
        check("rst_ready", pkt_ready, 1'b1);
        nrst = 1'b1;
        idleCycles(2);

        // Single packet: en two edges after acceptance, done three cycles later
        sendPkt(mkPkt(41, 3, 16'h1000, 16'h3000, 2, 41));
        step();
        check("t1_en", en, 1'b1);
        check("t1_src", fSourceID, 16'd41);
        idleCycles(2);
        pulseDone();
        idleCycles(2);
        check("t1_proc", proc_cnt, 16'd1);
        check("t1_busy", busy, 1'b0);

        // Self-echo filtering and saturation
        sendPkt(mkPkt(25, 1, 2, 3, 4, 5));
        idleCycles(3);
        check("t2_drop1", drop_cnt, 8'd1);
        repeat (300) sendPkt(mkPkt(25, 9, 9, 9, 9, 9));
        idleCycles(2);
        check("t2_drop_sat", drop_cnt, 8'd255);

        // Fill the queue while done is withheld; first op times out
        sendPkt(mkPkt(41, 1, 1, 1, 1, 1));
        sendPkt(mkPkt(65, 2, 2, 2, 2, 2));
        sendPkt(mkPkt(70, 3, 3, 3, 3, 3));
        sendPkt(mkPkt(80, 4, 4, 4, 4, 4));
        sendPkt(mkPkt(90, 5, 5, 5, 5, 5));
        check("t3_full", pkt_ready, 1'b0);
        idleCycles(70);
        check("t3_tout", timeout_err, 1'b1);
        check("t3_next", fSourceID, 16'd65);
        check("t3_proc", proc_cnt, 16'd1);
        idleCycles(3);
        pulseDone();

        // Heartbeat during WAIT_DONE with two packets queued
        idleCycles(3);
        pulseHb();
        idleCycles(2);
        pulseDone();
        idleCycles(50);
        check("t4_proc", proc_cnt, 16'd3);
        check("t4_flushed", exp_q.size(), 0);
        check("t4_ready", pkt_ready, 1'b1);

        // Reset mid-WAIT_DONE with three queued
        sendPkt(mkPkt(41, 1, 1, 1, 1, 1));
        sendPkt(mkPkt(65, 2, 2, 2, 2, 2));
        sendPkt(mkPkt(70, 3, 3, 3, 3, 3));
        sendPkt(mkPkt(80, 4, 4, 4, 4, 4));
        idleCycles(4);
        assertReset();
        idleCycles(10);
        check("t5_proc", proc_cnt, 16'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) doneMode = ($urandom_range(0, 3) != 0);
            pkt_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: pkt_srcID = 16'd25;
                1: pkt_srcID = 16'd41;
                2: pkt_srcID = 16'd65;
                3: pkt_srcID = 16'd70;
                4: pkt_srcID = 16'd80;
                default: pkt_srcID = W'($urandom);
            endcase
            pkt_srcHops    = W'($urandom);
            pkt_qValue     = W'($urandom);
            pkt_energy     = W'($urandom);
            pkt_hopsFromCH = W'($urandom);
            pkt_chosenCH   = W'($urandom);
            hb_req         = ($urandom_range(0, 119) == 0);
            QTUFMB_done    = doneMode && ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) assertReset();
            else step();
        end

        // Drain
        pkt_valid   = 1'b0;
        hb_req      = 1'b0;
        QTUFMB_done = 1'b1;
        idleCycles(120);
        check("end_drained", exp_q.size(), 0);
        check("end_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
